// File: rtl/cnn_pkg.sv
// Shared float32 helpers for the CNN post-processing stages (activation, pooling).
// Everything here assumes IEEE-754 single precision operands.
package cnn_pkg;

    localparam int unsigned FP_W    = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } row_par_e;

    // Any value with the sign bit set clamps to +0, including -0.0 and negative NaN.
    function automatic logic [31:0] relu_f32(input logic [31:0] x);
        return x[31] ? FP_ZERO : x;
    endfunction

    // Valid only for non-negative operands, where the raw bit order matches numeric order.
    function automatic logic [31:0] max_pos_f32(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_maxpool2d_if.sv
// Pixel stream in and pooled stream out of the ReLU + 2x2 max-pool stage.
// The slave modport is the pooling block, the master modport is its environment.
interface relu_maxpool2d_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  frame_done;

    modport master (
        output valid_in,
        output data_in,
        input  valid_out,
        input  data_out,
        input  frame_done
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output valid_out,
        output data_out,
        output frame_done
    );
endinterface

// File: rtl/pool_line_buffer.sv
// DEPTH x DATA_WIDTH register array, one synchronous write port, one combinational read port.
// Contents are deliberately not reset so the array maps onto distributed RAM.
module pool_line_buffer #(
    parameter  int DEPTH      = 56,
    parameter  int DATA_WIDTH = 32,
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/relu_maxpool2d.sv
// Streaming ReLU followed by 2x2 / stride-2 max pooling over a raster float32 feature map.
//   state  | meaning
//   S_EVEN | even input row: horizontal pair maxima are stored in the line buffer
//   S_ODD  | odd input row: pair maxima are combined with the stored ones and emitted
module relu_maxpool2d
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                   clk,
    input  logic                   rst,
    relu_maxpool2d_if.slave        bus
);

    localparam int COL_W    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int LB_DEPTH = (WIDTH / 2 > 0) ? WIDTH / 2 : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    if ((WIDTH % 2) != 0 || (HEIGHT % 2) != 0 || WIDTH < 2 || HEIGHT < 2) begin : g_bad_size
        $error("relu_maxpool2d: WIDTH and HEIGHT must be even and at least 2");
    end
    if (DATA_WIDTH != FP_W) begin : g_bad_width
        $error("relu_maxpool2d: DATA_WIDTH must be 32 (float32)");
    end

    row_par_e              state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] hreg_q, hreg_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic                  col_last;
    logic                  row_last;
    logic                  col_odd;
    logic [DATA_WIDTH-1:0] relu_in;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] pool_max;
    logic                  lb_we;
    logic [LB_AW-1:0]      lb_addr;
    logic [DATA_WIDTH-1:0] lb_rdata;

    assign col_last = (col_q == COL_W'(WIDTH - 1));
    assign row_last = (row_q == ROW_W'(HEIGHT - 1));
    assign col_odd  = col_q[0];
    assign relu_in  = relu_f32(bus.data_in);
    assign hmax     = max_pos_f32(hreg_q, relu_in);
    assign pool_max = max_pos_f32(hmax, lb_rdata);
    // Write (even row) and read (odd row) share one address but never occur in the same cycle.
    assign lb_addr  = LB_AW'(col_q >> 1);
    assign lb_we    = bus.valid_in && col_odd && (state_q == S_EVEN);

    pool_line_buffer #(
        .DEPTH      (LB_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (hmax),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_comb begin
        state_d = state_q;
        if (bus.valid_in && col_last) begin
            case (state_q)
                S_EVEN:  state_d = S_ODD;
                S_ODD:   state_d = S_EVEN;
                default: state_d = S_EVEN;
            endcase
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hreg_d = hreg_q;
        if (bus.valid_in) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_odd) begin
                hreg_d = relu_in;
            end
        end
    end

    always_comb begin
        valid_out_d  = bus.valid_in && col_odd && (state_q == S_ODD);
        frame_done_d = valid_out_d && row_last && col_last;
        data_out_d   = valid_out_d ? pool_max : data_out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            hreg_q       <= FP_ZERO;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= FP_ZERO;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hreg_q       <= hreg_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            data_out_q   <= data_out_d;
        end
    end

    assign bus.valid_out  = valid_out_q;
    assign bus.frame_done = frame_done_q;
    assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_relu_maxpool2d.sv
// Bench for relu_maxpool2d: a 4x2 instance for directed/table cases and a 112x112 instance
// for a full random frame, both checked against a plain window-max reference model.
module tb_relu_maxpool2d;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    relu_maxpool2d_if #(.DATA_WIDTH(32)) s_if ();
    relu_maxpool2d_if #(.DATA_WIDTH(32)) b_if ();

    relu_maxpool2d #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(2)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    relu_maxpool2d #(.DATA_WIDTH(32), .WIDTH(112), .HEIGHT(112)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    typedef struct {
        logic [31:0] data;
        logic        vo;
        logic        fd;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [31:0] px [8];
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    obs_t        obs_s [$];
    obs_t        obs_b [$];
    logic [31:0] stim  [$];
    int          acc   [$];
    vec_t        tv    [4];

    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        if (s_if.valid_out || s_if.frame_done)
            obs_s.push_back('{s_if.data_out, s_if.valid_out, s_if.frame_done, cyc});
        if (b_if.valid_out || b_if.frame_done)
            obs_b.push_back('{b_if.data_out, b_if.valid_out, b_if.frame_done, cyc});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] relu_m(input logic [31:0] x);
        return x[31] ? 32'd0 : x;
    endfunction

    task automatic start_scn();
        stim.delete();
        acc.delete();
        obs_s.delete();
        obs_b.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            s_if.valid_in = 1'b0;
            b_if.valid_in = 1'b0;
        end
    endtask

    task automatic drive_beat(input bit big, input logic [31:0] d, input int gap);
        idle(gap);
        @(posedge clk);
        #1;
        s_if.valid_in = !big;
        b_if.valid_in = big;
        if (big) b_if.data_in = d;
        else     s_if.data_in = d;
        stim.push_back(d);
        acc.push_back(cyc + 1);
    endtask

    // Reference: each output is the max of the ReLU'd 2x2 window, emitted one cycle
    // after the bottom-right pixel of that window is accepted.
    task automatic check_stream(input bit big, input int w, input int h, input string tag);
        obs_t        got [$];
        int          nf, n, k, base;
        logic [31:0] e, v;
        if (big) got = obs_b;
        else     got = obs_s;
        nf = stim.size() / (w * h);
        n  = nf * (w / 2) * (h / 2);
        chk({tag, " count"}, got.size(), n);
        k = 0;
        for (int f = 0; f < nf; f++) begin
            base = f * w * h;
            for (int r = 0; r < h / 2; r++) begin
                for (int c = 0; c < w / 2; c++) begin
                    e = 32'd0;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = relu_m(stim[base + (2 * r + dy) * w + 2 * c + dx]);
                            if (v > e) e = v;
                        end
                    if (k < got.size()) begin
                        chk({tag, " data"}, got[k].data, e);
                        chk({tag, " valid"}, 32'(got[k].vo), 32'd1);
                        chk({tag, " frame_done"}, 32'(got[k].fd),
                            32'((r == h / 2 - 1) && (c == w / 2 - 1)));
                        chk({tag, " latency"}, got[k].cyc, acc[base + (2 * r + 1) * w + 2 * c + 1]);
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic drive_vec(input int i, input int max_gap);
        for (int j = 0; j < 8; j++)
            drive_beat(1'b0, tv[i].px[j], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    endtask

    task automatic check_vec(input int i, input string tag);
        chk({tag, " vec count"}, obs_s.size(), 2);
        if (obs_s.size() >= 2) begin
            chk({tag, " out0"}, obs_s[0].data, tv[i].e0);
            chk({tag, " out1"}, obs_s[1].data, tv[i].e1);
            chk({tag, " fd0"}, 32'(obs_s[0].fd), 32'd0);
            chk({tag, " fd1"}, 32'(obs_s[1].fd), 32'd1);
        end
    endtask

    initial begin
        // rows are raster order: px[0..3] = row 0, px[4..7] = row 1
        tv[0].px = '{32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h40000000,
                     32'hC0000000, 32'h3F000000, 32'h3F800000, 32'h3F000000};
        tv[0].e0 = 32'h3F800000; tv[0].e1 = 32'h40000000;
        tv[1].px = '{32'hBF800000, 32'h80000000, 32'h7F800000, 32'h3F800000,
                     32'hC0000000, 32'hBF000000, 32'h7FC00000, 32'h00000001};
        tv[1].e0 = 32'h00000000; tv[1].e1 = 32'h7FC00000;
        tv[2].px = '{32'hFFC00000, 32'hFF800000, 32'h3F800000, 32'h3F800000,
                     32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800000};
        tv[2].e0 = 32'h00000000; tv[2].e1 = 32'h3F800000;
        tv[3].px = '{32'h00000001, 32'h00000002, 32'h41200000, 32'hC1200000,
                     32'h00000003, 32'h7F7FFFFF, 32'h40A00000, 32'hBF800000};
        tv[3].e0 = 32'h7F7FFFFF; tv[3].e1 = 32'h41200000;

        s_if.valid_in = 1'b0; s_if.data_in = '0;
        b_if.valid_in = 1'b0; b_if.data_in = '0;

        repeat (3) @(negedge clk);
        chk("reset valid_out", 32'(s_if.valid_out), 32'd0);
        chk("reset frame_done", 32'(s_if.frame_done), 32'd0);
        chk("reset data_out", s_if.data_out, 32'd0);
        chk("reset big valid_out", 32'(b_if.valid_out), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        idle(2);

        // table vectors, continuous beats
        for (int i = 0; i < 4; i++) begin
            start_scn();
            drive_vec(i, 0);
            idle(3);
            check_vec(i, $sformatf("tbl%0d", i));
            check_stream(1'b0, 4, 2, $sformatf("tbl%0d model", i));
            chk($sformatf("tbl%0d hold", i), s_if.data_out, tv[i].e1);
        end

        // gapped input
        for (int i = 0; i < 2; i++) begin
            start_scn();
            drive_vec(i, 5);
            idle(4);
            check_vec(i, $sformatf("gap%0d", i));
            check_stream(1'b0, 4, 2, $sformatf("gap%0d model", i));
        end

        // reset after 6 beats of a frame
        start_scn();
        for (int j = 0; j < 6; j++) drive_beat(1'b0, 32'h3F800000 + 32'(j), 0);
        idle(2);
        obs_s.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst valid_out", 32'(s_if.valid_out), 32'd0);
            chk("midrst frame_done", 32'(s_if.frame_done), 32'd0);
            chk("midrst data_out", s_if.data_out, 32'd0);
        end
        chk("midrst spurious", obs_s.size(), 0);
        @(posedge clk); #1 rst = 1'b1;
        start_scn();
        drive_vec(0, 0);
        idle(3);
        check_vec(0, "postrst");
        check_stream(1'b0, 4, 2, "postrst model");

        // back-to-back: random frame then the basic frame
        start_scn();
        for (int j = 0; j < 8; j++) drive_beat(1'b0, $urandom, 0);
        drive_vec(0, 0);
        idle(3);
        check_stream(1'b0, 4, 2, "b2b");
        if (obs_s.size() == 4) begin
            chk("b2b f2 out0", obs_s[2].data, 32'h3F800000);
            chk("b2b f2 out1", obs_s[3].data, 32'h40000000);
        end

        // random small frames with random gaps
        start_scn();
        for (int j = 0; j < 8 * 6; j++) drive_beat(1'b0, $urandom, $urandom_range(2, 0));
        idle(3);
        check_stream(1'b0, 4, 2, "rand4x2");

        // full default-size frame
        start_scn();
        for (int j = 0; j < 112 * 112; j++) drive_beat(1'b1, $urandom, 0);
        idle(3);
        check_stream(1'b1, 112, 112, "big");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
